// File: rtl/reg_cmd_sequencer.sv
// Register command sequencer: expands one accepted command into a burst of
// one-hot control pulses for the downstream register, then pulses done.
module reg_cmd_sequencer #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    input  logic [CNT_WIDTH-1:0]  cmd_count,
    input  logic                  cmd_fill,
    output logic                  cl,
    output logic                  ld,
    output logic                  inc,
    output logic                  dec,
    output logic                  sr,
    output logic                  sl,
    output logic                  ir,
    output logic                  il,
    output logic [DATA_WIDTH-1:0] in,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_INC  = 3'd3;
    localparam logic [2:0] OP_DEC  = 3'd4;
    localparam logic [2:0] OP_SHR  = 3'd5;
    localparam logic [2:0] OP_SHL  = 3'd6;

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  fill_q, fill_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  repeat_op;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            data_q  <= '0;
            fill_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
        end
    end

    assign repeat_op = (cmd_op == OP_INC) || (cmd_op == OP_DEC) ||
                       (cmd_op == OP_SHR) || (cmd_op == OP_SHL);

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    state_d = S_EXEC;
                    op_d    = cmd_op;
                    fill_d  = cmd_fill;
                    // in keeps the last LOAD value, so only LOAD may overwrite it
                    if (cmd_op == OP_LOAD) begin
                        data_d = cmd_data;
                    end
                    if (repeat_op && (cmd_count != '0)) begin
                        cnt_d = cmd_count;
                    end else begin
                        cnt_d = CNT_WIDTH'(1);
                    end
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - CNT_WIDTH'(1);
                if (cnt_q == CNT_WIDTH'(1)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control lines decode only registered state, never the cmd_* inputs
    always_comb begin
        cl  = 1'b0;
        ld  = 1'b0;
        inc = 1'b0;
        dec = 1'b0;
        sr  = 1'b0;
        sl  = 1'b0;
        ir  = 1'b0;
        il  = 1'b0;
        if (state_q == S_EXEC) begin
            case (op_q)
                OP_CLR:  cl  = 1'b1;
                OP_LOAD: ld  = 1'b1;
                OP_INC:  inc = 1'b1;
                OP_DEC:  dec = 1'b1;
                OP_SHR: begin
                    sr = 1'b1;
                    ir = fill_q;
                end
                OP_SHL: begin
                    sl = 1'b1;
                    il = fill_q;
                end
                default: ;
            endcase
        end
    end

    assign in        = data_q;
    assign busy      = (state_q != S_IDLE);
    assign cmd_ready = !busy;
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_reg_cmd_sequencer.sv
// Scoreboard bench for reg_cmd_sequencer with a behavioural model of the
// downstream register driven by the sequencer's control outputs.
module tb_reg_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [15:0] cmd_data = '0;
    logic [3:0]  cmd_count = '0;
    logic        cmd_fill = 1'b0;
    logic        cl, ld, inc, dec, sr, sl, ir, il;
    logic [15:0] in;
    logic        busy, done;

    reg_cmd_sequencer #(.DATA_WIDTH(16), .CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
        .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl),
        .ir(ir), .il(il), .in(in), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] data;
        logic        fill;
        int          n;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   done_cnt = 0;

    logic [5:0] ctl;
    assign ctl = {sl, sr, dec, inc, ld, cl};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int exp_pulses(input logic [2:0] op, input logic [3:0] cnt);
        if (op >= 3'd3 && op <= 3'd6) return (cnt == 4'd0) ? 1 : int'(cnt);
        return 1;
    endfunction

    // Downstream register model
    logic [15:0] reg_m = '0;
    always @(posedge clk) begin
        if (cl)       reg_m <= 16'h0000;
        else if (ld)  reg_m <= in;
        else if (inc) reg_m <= reg_m + 16'd1;
        else if (dec) reg_m <= reg_m - 16'd1;
        else if (sr)  reg_m <= {ir, reg_m[15:1]};
        else if (sl)  reg_m <= {reg_m[14:0], il};
    end

    // Monitor: collects each burst and compares it against the scoreboard head
    bit   in_burst = 0;
    int   pc[6];
    int   busy_cyc, fill_err, data_err;
    exp_t cur;

    always @(negedge clk) begin
        if (rst) begin
            in_burst = 0;
        end else begin
            check_eq("ready_vs_busy", cmd_ready, !busy);
            check_eq("onehot", $onehot0(ctl), 1);
            check_eq("ir_gate", ir && !sr, 0);
            check_eq("il_gate", il && !sl, 0);
            if (busy) begin
                if (!in_burst) begin
                    in_burst = 1;
                    for (int i = 0; i < 6; i++) pc[i] = 0;
                    busy_cyc = 0;
                    fill_err = 0;
                    data_err = 0;
                    check_eq("busy_has_cmd", sb.size() != 0, 1);
                    if (sb.size() != 0) cur = sb[0];
                end
                busy_cyc++;
                for (int i = 0; i < 6; i++) pc[i] += int'(ctl[i]);
                if ((sr && ir != cur.fill) || (sl && il != cur.fill)) fill_err++;
                if (ld && in != cur.data) data_err++;
            end
            if (done) begin
                done_cnt++;
                check_eq("done_ctl_quiet", ctl, 0);
                check_eq("done_in_burst", in_burst, 1);
                if (in_burst && sb.size() != 0) begin
                    cur = sb.pop_front();
                    for (int i = 0; i < 6; i++)
                        check_eq($sformatf("pulses_op%0d_line%0d", cur.op, i), pc[i],
                                 (cur.op >= 3'd1 && cur.op <= 3'd6 && int'(cur.op) - 1 == i) ? cur.n : 0);
                    check_eq("occupancy", busy_cyc + 1, cur.n + 2);
                    check_eq("fill_bits", fill_err, 0);
                    check_eq("load_data", data_err, 0);
                end
                in_burst = 0;
            end
        end
    end

    // Called between a rising and the following falling edge; returns 1ns after the accepting edge
    task automatic send(input logic [2:0] op, input logic [15:0] d, input logic [3:0] c,
                        input logic f, input bit keep_valid, output int waited);
        exp_t e;
        waited = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_data = d;
        cmd_count = c;
        cmd_fill = f;
        @(negedge clk);
        while (!cmd_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (waited >= 200) check_eq("accept_timeout", waited, 0);
        e.op = op;
        e.data = d;
        e.fill = f;
        e.n = exp_pulses(op, c);
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (!keep_valid) cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((sb.size() != 0 || busy) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) check_eq("drain_timeout", t, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int dc;
        #1 rst = 1'b1;
        #2;
        check_eq("rst_ctl", {ctl, ir, il}, 0);
        check_eq("rst_ready", cmd_ready, 1);
        check_eq("rst_busy_done", {busy, done}, 0);
        check_eq("rst_in", in, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        send(3'd2, 16'hA5C3, 4'd0, 1'b0, 0, w);
        drain();
        check_eq("reg_after_load", reg_m, 16'hA5C3);

        send(3'd1, 16'h1234, 4'd0, 1'b0, 0, w);
        send(3'd5, 16'h5555, 4'd5, 1'b1, 0, w);
        drain();
        check_eq("reg_after_shr5", reg_m, 16'hF800);
        check_eq("in_hold", in, 16'hA5C3);

        send(3'd1, 16'h0, 4'd0, 1'b0, 0, w);
        send(3'd3, 16'h0, 4'd0, 1'b0, 0, w);
        send(3'd4, 16'h0, 4'd15, 1'b0, 0, w);
        drain();
        check_eq("reg_after_incdec", reg_m, 16'hFFF2);

        send(3'd1, 16'h0, 4'd0, 1'b0, 1, w);
        send(3'd6, 16'hFFFF, 4'd3, 1'b0, 0, w);
        check_eq("b2b_gap", w, 2);
        drain();
        check_eq("reg_after_shl3", reg_m, 16'h0000);

        send(3'd7, 16'hBEEF, 4'd9, 1'b1, 0, w);
        send(3'd4, 16'h0, 4'd15, 1'b1, 0, w);
        for (int i = 0; i < 10; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op = 3'($urandom);
            cmd_data = 16'($urandom);
            cmd_count = 4'($urandom);
            cmd_fill = 1'($urandom);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        drain();
        check_eq("reg_after_dec15", reg_m, 16'hFFF1);
        check_eq("in_hold2", in, 16'hA5C3);

        send(3'd6, 16'h0, 4'd8, 1'b1, 0, w);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_ctl", {ctl, ir, il}, 0);
        check_eq("abort_ready", cmd_ready, 1);
        check_eq("abort_busy_done", {busy, done}, 0);
        check_eq("abort_in", in, 0);
        sb.delete();
        dc = done_cnt;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("abort_no_done", done_cnt, dc);
        send(3'd0, 16'h0, 4'd7, 1'b1, 0, w);
        drain();
        check_eq("nop_done_seen", done_cnt, dc + 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
